// File: rtl/aes_cipher_core.sv
// aes_cipher_core -- iterative AES encryptor for 128/192/256-bit keys, one
// round per clock. The key schedule is expanded once per key load into an
// internal word store; blocks then stream through valid/ready handshakes.
//
// Parameters
//   KEY_BITS   128, 192 or 256 (anything else fails elaboration)
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   key_valid/key_ready key load handshake; key is MSB-justified in key[255:0]
//   in_valid/in_ready   plaintext handshake, in_data in FIPS-197 byte order
//   out_valid/out_ready result handshake, out_data held until accepted
//   key_loaded          round-key store holds a complete schedule
//   busy                core is not IDLE
// Build option
//   AES_CIPHER_CORE_CTR_EN adds ctr_mode/iv and a 128-bit counter; with
//   ctr_mode=1 the counter is encrypted and XORed with the latched in_data.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // FIPS-197 S-box; the first listed byte (S[0x00]) lands at index 255.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = SBOX[~a];
endmodule

module aes_cipher_core #(
  parameter int KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef AES_CIPHER_CORE_CTR_EN
  input  logic         ctr_mode,
  input  logic [127:0] iv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         key_loaded,
  output logic         busy
);
  localparam int NK   = KEY_BITS / 32;
  localparam int NR   = NK + 6;
  localparam int NW   = 4 * (NR + 1);
  localparam int WI_W = $clog2(NW);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_cipher_core: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;
  state_e state;

  logic [NW-1:0][31:0] w;     // round-key store, w[0] = first key word
  logic [NK-1:0][31:0] win;   // last NK words: win[0]=w[i-NK], win[NK-1]=w[i-1]
  logic [WI_W-1:0]     wi;
  logic [2:0]          wmod;  // wi mod NK, kept as a counter
  logic [7:0]          rcon;
  logic [127:0]        st;
  logic [3:0]          rnd;
  logic                key_hs, in_hs;
  logic [127:0]        blk_in;
  logic                unused_key;

  assign unused_key = ^key;   // low bits beyond KEY_BITS are ignored

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  assign in_ready = key_ready & key_loaded & ~key_valid;
  assign key_hs   = key_valid & key_ready;
  assign in_hs    = in_valid & in_ready;

`ifdef AES_CIPHER_CORE_CTR_EN
  logic [127:0] ctr, pt_lat;
  logic         ctr_blk;
  assign blk_in = ctr_mode ? ctr : in_data;
`else
  assign blk_in = in_data;
`endif

  // Key expansion: SubWord commutes with RotWord, so one set of S-boxes on
  // w[i-1] serves both the rotated and the NK==8 unrotated cases.
  logic [31:0] sw, wtmp, w_new;
  for (genvar g = 0; g < 4; g++) begin : g_sw
    aes_sbox u_sbox (.a(win[NK-1][8*g +: 8]), .y(sw[8*g +: 8]));
  end

  always_comb begin
    wtmp = win[NK-1];
    if (wmod == 3'd0)                 wtmp = {sw[23:0], sw[31:24]} ^ {rcon, 24'h0};
    else if (NK == 8 && wmod == 3'd4) wtmp = sw;
    w_new = win[0] ^ wtmp;
  end

  // Round datapath: byte k of the state lives at st[127-8k -: 8].
  logic [127:0] sb, sr, mc, rk, rk0, nxt;
  for (genvar g = 0; g < 16; g++) begin : g_sb
    aes_sbox u_sbox (.a(st[8*g +: 8]), .y(sb[8*g +: 8]));
  end

  assign rk0 = {w[0], w[1], w[2], w[3]};

  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    rk  = {w[WI_W'({rnd, 2'd0})], w[WI_W'({rnd, 2'd1})],
           w[WI_W'({rnd, 2'd2})], w[WI_W'({rnd, 2'd3})]};
    nxt = ((rnd == 4'(NR)) ? sr : mc) ^ rk;
  end

  // Control FSM; all block outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_ready  <= 1'b1;
      key_loaded <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      rnd        <= '0;
      wi         <= '0;
      wmod       <= '0;
      rcon       <= 8'h01;
`ifdef AES_CIPHER_CORE_CTR_EN
      ctr        <= '0;
      ctr_blk    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (key_hs) begin
            state      <= KEYEXP;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            key_loaded <= 1'b0;
            wi         <= WI_W'(NK);
            wmod       <= '0;
            rcon       <= 8'h01;
`ifdef AES_CIPHER_CORE_CTR_EN
            ctr        <= iv;
`endif
          end else if (in_hs) begin
            state     <= ROUND;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            rnd       <= 4'd1;
`ifdef AES_CIPHER_CORE_CTR_EN
            ctr_blk   <= ctr_mode;
            if (ctr_mode) ctr <= ctr + 128'd1;
`endif
          end
        end
        KEYEXP: begin
          wi   <= wi + 1'b1;
          wmod <= (wmod == 3'(NK-1)) ? 3'd0 : wmod + 3'd1;
          if (wmod == 3'd0) rcon <= xt(rcon);
          if (wi == WI_W'(NW-1)) begin
            state      <= IDLE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            key_loaded <= 1'b1;
          end
        end
        ROUND: begin
          rnd <= rnd + 4'd1;
          if (rnd == 4'(NR)) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef AES_CIPHER_CORE_CTR_EN
            out_data  <= ctr_blk ? (nxt ^ pt_lat) : nxt;
`else
            out_data  <= nxt;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (key_hs) begin
      for (int j = 0; j < NK; j++) begin
        w[j]   <= key[255-32*j -: 32];
        win[j] <= key[255-32*j -: 32];
      end
    end else if (state == KEYEXP) begin
      w[wi] <= w_new;
      win   <= {w_new, win[NK-1:1]};
    end
    if (in_hs)               st <= blk_in ^ rk0;
    else if (state == ROUND) st <= nxt;
`ifdef AES_CIPHER_CORE_CTR_EN
    if (in_hs) pt_lat <= in_data;
`endif
  end
endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Parametrised iterative AES encryption core for 128-, 192- and 256-bit keys, one cipher round per clock. It is the next-generation replacement for the fixed AES-256 multi-phase encrypt FSM. Round keys are expanded once per key load into an internal round-key store, and blocks stream through valid/ready handshakes. The core sits between the host key/data registers and the output FIFO of the crypto datapath and reuses the team's SubBytes, ShiftRows, MixColumns and AddRoundKey combinational blocks.

## Interface
- KEY_BITS, 256, key length: 128, 192 or 256; any other value is an elaboration error. Derived values: NK = KEY_BITS/32, NR = NK+6.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- key_valid  in  1  key load request
- key_ready  out  1  core accepts key this cycle
- key  in  256  cipher key, MSB-justified: key[255 -: KEY_BITS]; unused low bits ignored
- in_valid  in  1  plaintext block valid
- in_ready  out  1  core accepts block this cycle
- in_data  in  128  plaintext, FIPS-197 byte order (byte 0 = bits 127:120)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  128  ciphertext (or CTR output, see Configuration)
- key_loaded  out  1  round-key store holds a complete, valid schedule
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, KEYEXP, ROUND, DONE. Reset state is IDLE. Reset values: key_ready=1, in_ready=0, out_valid=0, out_data=0, key_loaded=0, busy=0.
- key_ready = (state==IDLE). in_ready = (state==IDLE) && key_loaded && !key_valid. A pending key load takes priority over a data block.
- Key handshake (key_valid && key_ready): words w[0..NK-1] are written from key, key_loaded is cleared, and the state moves to KEYEXP. KEYEXP generates one word w[i] per cycle for i = NK .. 4*(NR+1)-1, following FIPS-197 (RotWord/SubWord/Rcon when i mod NK == 0; SubWord only when NK==8 and i mod 8 == 4). After the last word, key_loaded is set and the state returns to IDLE.
- Rcon is generated by an 8-bit GF(2^8) doubling register starting at 0x01 (sequence 01..80, 1b, 36).
- Data handshake: state <= in_data ^ roundkey[0], round counter r <= 1, and the state moves to ROUND.
- ROUND: each cycle, state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[r]), with MixColumns bypassed when r==NR. r increments each cycle. When r==NR, the result goes to out_data and the state moves to DONE.
- DONE: out_valid=1, and out_data is held stable until out_ready. When out_valid && out_ready, the state moves to IDLE and out_valid is cleared.
- key_valid during ROUND or DONE is not accepted. The current block completes with the old schedule.
- Asynchronous reset mid-operation: immediately returns to reset values. key_loaded=0, so a key must be reloaded. The round-key store contents are don't-care.

## Timing
- Key load latency: 4*(NR+1)-NK cycles from the handshake to key_loaded=1. This is 40, 46 and 52 cycles for 128, 192 and 256.
- Block latency: the handshake in cycle t gives out_valid=1 at cycle t+NR+1.
- in_ready is low from t+1 until the cycle after the output handshake. With out_ready held high, peak throughput is one block per NR+2 cycles.
- Outputs are registered. No combinational path runs from in_* or key_* to out_*.

## Configuration
- AES_CIPHER_CORE_CTR_EN: adds ports ctr_mode (in, 1) and iv (in, 128), plus a 128-bit counter register.
  - The counter loads from iv on every key handshake; its reset value is 0.
  - When ctr_mode=1 at a data handshake, the cipher input is the counter, not in_data. in_data is latched, and out_data = E(ctr) ^ in_data.
  - The counter increments by 1 mod 2^128 at every data handshake taken with ctr_mode=1. FFFF..FF wraps to 0000..00.
  - ctr_mode=0 behaves as plain ECB.
- Without the macro, the ports and counter do not exist and the core is ECB-only.

## Test plan
- KEY_BITS=128, key 000102..0f, pt 00112233445566778899aabbccddeeff -> key_loaded after 40 cycles; out_data 69c4e0d86a7b0430d8cdb78070b4c55a at t+11.
- KEY_BITS=192, key 000102..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 at t+13; KEY_BITS=256, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 at t+15.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0; release -> IDLE next cycle, next block accepted.
- key_valid asserted during ROUND -> key_ready=0, current ciphertext correct with old key; new key accepted in IDLE and in_valid blocked until key_loaded.
- rst_n pulsed at round 5 -> out_valid=0 and key_loaded=0 immediately; in_ready stays 0 until a key is reloaded.
- CTR build, KEY_BITS=128, iv FFFF..FF, two blocks of zeros -> out1=E(FFFF..FF), out2=E(0000..00), confirming wrap-around.
